// File: rtl/amm_perf_meter.sv
// ---------------------------------------------------------------------------
// amm_perf_meter
//
// Passive Avalon-MM performance meter. Snoops the master side of the bus and
// collects write throughput, read throughput and per-burst read latency
// statistics (min / max / saturating sum) over a measurement window that is
// opened by test_start_i and closed by test_stop_i. Outstanding read bursts
// are tracked in a small circular buffer so each burst's first-beat latency
// can be measured independently.
//
// Optional feature: define AMM_PERF_HIST_EN to build a latency histogram of
// HIST_BINS saturating 32-bit bins, each HIST_STEP cycles wide. Without the
// macro, hist_o is tied to zero and no histogram logic exists.
//
// Ports
//   clk_i, rst_n_i        clock, asynchronous active-low reset
//   read_i, write_i       Avalon read / write strobes
//   waitrequest_i         Avalon waitrequest (stalls acceptance)
//   readdatavalid_i       Avalon read data beat
//   burstcount_i          burst length of the read being issued
//   byteenable_i          byte lanes of the write being issued
//   test_start_i          pulse: clear all results, start measuring
//   test_stop_i           pulse: stop issue-side counting, drain reads
//   meas_busy_o           measuring (RUN or DRAIN)
//   meas_done_o           measurement finished, results stable
//   err_o                 sticky: [0] tracker overflow, [1] stray beat
//   wr_ticks_o            cycles with write_i high
//   wr_units_o            bytes (BYTE) or beats (WORD) written
//   rd_ticks_o            cycles with a read pending or outstanding
//   rd_words_o            readdatavalid beats
//   rd_req_o              accepted read requests
//   min_lat_o, max_lat_o  first-beat read latency extremes
//   sum_lat_o             saturating latency sum
//   hist_o                latency histogram, bin i at [32*i +: 32]
// ---------------------------------------------------------------------------
module amm_perf_meter #(
  parameter int    AMM_BURST_W = 11,
  parameter int    DATA_B_W    = 8,
  parameter string ADDR_TYPE   = "BYTE",
  parameter int    OUTSTD_NUM  = 8,
  parameter int    LAT_W       = 16,
  parameter int    SUM_W       = 40,
  parameter int    HIST_BINS   = 8,
  parameter int    HIST_STEP   = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_n_i,
  input  logic                    read_i,
  input  logic                    write_i,
  input  logic                    waitrequest_i,
  input  logic                    readdatavalid_i,
  input  logic [AMM_BURST_W-1:0]  burstcount_i,
  input  logic [DATA_B_W-1:0]     byteenable_i,
  input  logic                    test_start_i,
  input  logic                    test_stop_i,
  output logic                    meas_busy_o,
  output logic                    meas_done_o,
  output logic [1:0]              err_o,
  output logic [31:0]             wr_ticks_o,
  output logic [31:0]             wr_units_o,
  output logic [31:0]             rd_ticks_o,
  output logic [31:0]             rd_words_o,
  output logic [31:0]             rd_req_o,
  output logic [LAT_W-1:0]        min_lat_o,
  output logic [LAT_W-1:0]        max_lat_o,
  output logic [SUM_W-1:0]        sum_lat_o,
  output logic [HIST_BINS*32-1:0] hist_o
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam int PTR_W = $clog2(OUTSTD_NUM);
  localparam int OCC_W = PTR_W + 1;
  localparam logic [LAT_W-1:0] LAT_MAX = '1;
  localparam logic [SUM_W-1:0] SUM_MAX = '1;

  // Elaboration-time parameter sanity checks.
  if (OUTSTD_NUM < 2 || OUTSTD_NUM > 64 || (OUTSTD_NUM & (OUTSTD_NUM - 1)) != 0) begin : g_chk_outstd
    $error("amm_perf_meter: OUTSTD_NUM must be a power of two in 2..64");
  end
  if (HIST_BINS < 2 || HIST_STEP < 1) begin : g_chk_hist
    $error("amm_perf_meter: HIST_BINS must be >= 2 and HIST_STEP >= 1");
  end
  if (SUM_W <= LAT_W || DATA_B_W < 2) begin : g_chk_width
    $error("amm_perf_meter: need SUM_W > LAT_W and DATA_B_W >= 2");
  end
  if (ADDR_TYPE != "BYTE" && ADDR_TYPE != "WORD") begin : g_chk_addr
    $error("amm_perf_meter: ADDR_TYPE must be \"BYTE\" or \"WORD\"");
  end

  // -------------------------------------------------------------------------
  // Measurement FSM
  // -------------------------------------------------------------------------
  logic [1:0] state_q, state_d;
  logic       in_run, in_active;
  logic       trk_empty, wr_pipe_busy;

  assign in_run    = (state_q == S_RUN);
  assign in_active = (state_q == S_RUN) || (state_q == S_DRAIN);

  // NOTE: every combinational output gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RUN:   if (test_stop_i) state_d = S_DRAIN;
      S_DRAIN: if (trk_empty && !wr_pipe_busy) state_d = S_DONE;
      default: state_d = state_q;
    endcase
    if (test_start_i) state_d = S_RUN;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of every other flop regardless of block order.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  assign meas_busy_o = in_active;
  assign meas_done_o = (state_q == S_DONE);

  // -------------------------------------------------------------------------
  // Bus events
  // -------------------------------------------------------------------------
  logic rd_acc, wr_acc, beat;
  assign rd_acc = read_i  && !waitrequest_i;
  assign wr_acc = write_i && !waitrequest_i;
  assign beat   = in_active && readdatavalid_i;

  // -------------------------------------------------------------------------
  // Outstanding read-burst tracker
  // -------------------------------------------------------------------------
  logic [AMM_BURST_W-1:0] words_q [OUTSTD_NUM];
  logic [LAT_W-1:0]       age_q   [OUTSTD_NUM];
  logic [PTR_W-1:0]       load_ptr_q, act_ptr_q;
  logic [OCC_W-1:0]       occ_q;
  logic                   act_started_q;

  logic                   trk_full, push, retire_beat, first_beat, last_beat;
  logic [LAT_W-1:0]       cur_age, first_lat;

  assign trk_empty   = (occ_q == '0);
  assign trk_full    = (occ_q == OCC_W'(OUTSTD_NUM));
  assign push        = in_run && rd_acc && !trk_full;
  // A beat always belongs to the oldest burst; a burst pushed this cycle is
  // not yet visible, so a same-cycle beat cannot be attributed to it.
  assign retire_beat = beat && !trk_empty;
  assign first_beat  = retire_beat && !act_started_q;
  assign last_beat   = retire_beat && (words_q[act_ptr_q] == AMM_BURST_W'(1));
  assign cur_age     = age_q[act_ptr_q];
  // age counts completed cycles since acceptance; the beat cycle adds one.
  assign first_lat   = (cur_age == LAT_MAX) ? LAT_MAX : cur_age + LAT_W'(1);

  // NOTE: the tracker payload arrays are deliberately not reset; an entry is
  // only read while the occupancy count says it is valid, and push always
  // initialises it first.
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < OUTSTD_NUM; i++) begin
      if (age_q[i] != LAT_MAX) age_q[i] <= age_q[i] + LAT_W'(1);
    end
    if (push) begin
      words_q[load_ptr_q] <= (burstcount_i == '0) ? AMM_BURST_W'(1) : burstcount_i;
      age_q[load_ptr_q]   <= '0;
    end
    // push never targets the active slot: it is blocked when the ring is full.
    if (retire_beat && !last_beat) begin
      words_q[act_ptr_q] <= words_q[act_ptr_q] - AMM_BURST_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      load_ptr_q    <= '0;
      act_ptr_q     <= '0;
      occ_q         <= '0;
      act_started_q <= 1'b0;
    end else if (test_start_i) begin
      load_ptr_q    <= '0;
      act_ptr_q     <= '0;
      occ_q         <= '0;
      act_started_q <= 1'b0;
    end else begin
      if (push) load_ptr_q <= load_ptr_q + PTR_W'(1);
      if (last_beat) begin
        act_ptr_q     <= act_ptr_q + PTR_W'(1);
        act_started_q <= 1'b0;
      end else if (retire_beat) begin
        act_started_q <= 1'b1;
      end
      occ_q <= occ_q + OCC_W'(push) - OCC_W'(last_beat);
    end
  end

  // -------------------------------------------------------------------------
  // Write unit counting
  // -------------------------------------------------------------------------
  logic [31:0] wr_add;

  if (ADDR_TYPE == "BYTE") begin : g_byte
    localparam int BE_LO = DATA_B_W / 2;
    localparam int PC_W  = $clog2(DATA_B_W + 1);

    logic [PC_W-1:0] pc_lo, pc_hi;
    logic [PC_W-1:0] s1_lo_q, s1_hi_q, s2_sum_q;
    logic            s1_v_q, s2_v_q;

    always_comb begin
      pc_lo = '0;
      pc_hi = '0;
      for (int i = 0; i < BE_LO; i++)        pc_lo = pc_lo + PC_W'(byteenable_i[i]);
      for (int i = BE_LO; i < DATA_B_W; i++) pc_hi = pc_hi + PC_W'(byteenable_i[i]);
    end

    // Stage 1 registers the two half popcounts, stage 2 their sum.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
        s1_v_q   <= 1'b0;
        s2_v_q   <= 1'b0;
        s1_lo_q  <= '0;
        s1_hi_q  <= '0;
        s2_sum_q <= '0;
      end else if (test_start_i) begin
        s1_v_q   <= 1'b0;
        s2_v_q   <= 1'b0;
      end else begin
        s1_v_q   <= in_run && wr_acc;
        s1_lo_q  <= pc_lo;
        s1_hi_q  <= pc_hi;
        s2_v_q   <= s1_v_q;
        s2_sum_q <= s1_lo_q + s1_hi_q;
      end
    end

    assign wr_add       = s2_v_q ? 32'(s2_sum_q) : 32'd0;
    assign wr_pipe_busy = s1_v_q || s2_v_q;
  end else begin : g_word
    assign wr_add       = (in_run && wr_acc) ? 32'd1 : 32'd0;
    assign wr_pipe_busy = 1'b0;
  end

  // -------------------------------------------------------------------------
  // Throughput counters and sticky errors
  // -------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ticks_o <= '0;
      wr_units_o <= '0;
      rd_ticks_o <= '0;
      rd_words_o <= '0;
      rd_req_o   <= '0;
      err_o      <= '0;
    end else if (test_start_i) begin
      wr_ticks_o <= '0;
      wr_units_o <= '0;
      rd_ticks_o <= '0;
      rd_words_o <= '0;
      rd_req_o   <= '0;
      err_o      <= '0;
    end else begin
      if (in_run && write_i)                      wr_ticks_o <= wr_ticks_o + 32'd1;
      wr_units_o <= wr_units_o + wr_add;
      if (in_active && (read_i || !trk_empty))    rd_ticks_o <= rd_ticks_o + 32'd1;
      if (beat)                                   rd_words_o <= rd_words_o + 32'd1;
      if (in_run && rd_acc)                       rd_req_o   <= rd_req_o + 32'd1;
      if (in_run && rd_acc && trk_full)           err_o[0]   <= 1'b1;
      if (beat && trk_empty)                      err_o[1]   <= 1'b1;
    end
  end

  // -------------------------------------------------------------------------
  // Latency statistics: register the first-beat latency, update one cycle on
  // -------------------------------------------------------------------------
  logic             lat_v_q;
  logic [LAT_W-1:0] lat_q;
  logic [SUM_W:0]   sum_ext;

  assign sum_ext = {1'b0, sum_lat_o} + (SUM_W+1)'(lat_q);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      lat_v_q   <= 1'b0;
      lat_q     <= '0;
      min_lat_o <= LAT_MAX;
      max_lat_o <= '0;
      sum_lat_o <= '0;
    end else if (test_start_i) begin
      lat_v_q   <= 1'b0;
      min_lat_o <= LAT_MAX;
      max_lat_o <= '0;
      sum_lat_o <= '0;
    end else begin
      lat_v_q <= first_beat;
      lat_q   <= first_lat;
      if (lat_v_q) begin
        if (lat_q < min_lat_o) min_lat_o <= lat_q;
        if (lat_q > max_lat_o) max_lat_o <= lat_q;
        sum_lat_o <= sum_ext[SUM_W] ? SUM_MAX : sum_ext[SUM_W-1:0];
      end
    end
  end

  // -------------------------------------------------------------------------
  // Optional latency histogram
  // -------------------------------------------------------------------------
`ifdef AMM_PERF_HIST_EN
  localparam int BIN_W = $clog2(HIST_BINS);

  logic [31:0]      bins_q [HIST_BINS];
  logic [LAT_W-1:0] bin_quot;
  logic [BIN_W-1:0] bin_idx;

  always_comb begin
    bin_quot = lat_q / LAT_W'(HIST_STEP);
    if (bin_quot >= LAT_W'(HIST_BINS - 1)) bin_idx = BIN_W'(HIST_BINS - 1);
    else                                   bin_idx = bin_quot[BIN_W-1:0];
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < HIST_BINS; i++) bins_q[i] <= '0;
    end else if (test_start_i) begin
      for (int i = 0; i < HIST_BINS; i++) bins_q[i] <= '0;
    end else if (lat_v_q && bins_q[bin_idx] != '1) begin
      bins_q[bin_idx] <= bins_q[bin_idx] + 32'd1;
    end
  end

  for (genvar g = 0; g < HIST_BINS; g++) begin : g_hist_out
    assign hist_o[g*32 +: 32] = bins_q[g];
  end
`else
  assign hist_o = '0;
`endif

endmodule
